// File: rtl/datapath_pkg.sv
// Shared datapath definitions: default width, accumulator opcodes, ALU control codes
// and the accumulator FSM state type.
package datapath_pkg;

  localparam int DP_WIDTH = 16;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_LDA = 3'd1;
  localparam logic [2:0] CMD_LDB = 3'd2;
  localparam logic [2:0] CMD_CLR = 3'd3;
  localparam logic [2:0] CMD_INC = 3'd4;
  localparam logic [2:0] CMD_SHL = 3'd5;
  localparam logic [2:0] CMD_SHR = 3'd6;

  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } acc_state_e;

endpackage

// File: rtl/accumulator_unit.sv
// Accumulator register with load/clear/increment and multi-cycle serial shifts,
// driven by a valid/ready command interface.
//
//   state    | meaning
//   ST_IDLE  | ready for a command; single-cycle ops complete here
//   ST_SHIFT | serial shift in flight, one bit per clock, count_q bits remaining
module accumulator_unit
  import datapath_pkg::*;
#(
  parameter int WIDTH   = DP_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         cmd,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   alu_in,
  input  logic [WIDTH-1:0]   bus_in,
  output logic [WIDTH-1:0]   ac_out,
  output logic               zero,
  output logic               neg,
  output logic               busy,
  output logic               done
);

  acc_state_e         state_q;
  logic [WIDTH-1:0]   ac_q;
  logic [SHAMT_W-1:0] count_q;
  logic               dir_right_q;
  logic               done_q;

  logic accept;
  logic is_shift;
  logic start_shift;

  assign accept      = cmd_valid && (state_q == ST_IDLE);
  assign is_shift    = (cmd == CMD_SHL) || (cmd == CMD_SHR);
  assign start_shift = accept && is_shift && (shamt != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ac_q        <= '0;
      count_q     <= '0;
      dir_right_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (cmd)
              CMD_LDA: ac_q <= alu_in;
              CMD_LDB: ac_q <= bus_in;
              CMD_CLR: ac_q <= '0;
              CMD_INC: ac_q <= ac_q + WIDTH'(1);
              default: ;
            endcase
            // A non-zero shift completes later from ST_SHIFT; everything else is done now.
            if (start_shift) begin
              dir_right_q <= (cmd == CMD_SHR);
              count_q     <= shamt;
              state_q     <= ST_SHIFT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          ac_q    <= dir_right_q ? (ac_q >> 1) : (ac_q << 1);
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ac_out    = ac_q;
  assign zero      = (ac_q == '0);
  assign neg       = ac_q[WIDTH-1];
  assign busy      = (state_q == ST_SHIFT);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed bench for accumulator_unit: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed.
module tb_accumulator_unit;
  import datapath_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  shamt;
  logic [15:0] alu_in;
  logic [15:0] bus_in;
  logic [15:0] ac_out;
  logic        zero;
  logic        neg;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  accumulator_unit dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .shamt     (shamt),
    .alu_in    (alu_in),
    .bus_in    (bus_in),
    .ac_out    (ac_out),
    .zero      (zero),
    .neg       (neg),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
    end
  endtask

  // Presents one command for exactly one rising edge; returns on the following falling edge.
  task automatic issue(input logic [2:0] c, input logic [3:0] s);
    cmd       = c;
    shamt     = s;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    shamt     = '0;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk_eq({tag, "_ac"},    ac_out, 16'h0000);
    chk_eq({tag, "_zero"},  16'(zero), 16'd1);
    chk_eq({tag, "_neg"},   16'(neg), 16'd0);
    chk_eq({tag, "_busy"},  16'(busy), 16'd0);
    chk_eq({tag, "_ready"}, 16'(cmd_ready), 16'd1);
    chk_eq({tag, "_done"},  16'(done), 16'd0);
  endtask

  initial begin
    reset = 1'b1; cmd = CMD_NOP; cmd_valid = 1'b0; shamt = '0;
    alu_in = 16'h0000; bus_in = 16'h0000;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_idle_reset("por");

    // 1: reset mid-stream
    bus_in = 16'h1234; issue(CMD_LDB, 4'd0);
    chk_eq("pre_rst_ac", ac_out, 16'h1234);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_idle_reset("rst_mid");

    // 2: LDB then LDA back to back
    bus_in = 16'h0005; alu_in = 16'h0009;
    issue(CMD_LDB, 4'd0);
    chk_eq("ldb_ac", ac_out, 16'h0005);
    chk_eq("ldb_done", 16'(done), 16'd1);
    chk_eq("ldb_zero", 16'(zero), 16'd0);
    bus_in = 16'h7777;
    issue(CMD_LDA, 4'd0);
    chk_eq("lda_ac", ac_out, 16'h0009);
    chk_eq("lda_done", 16'(done), 16'd1);
    @(negedge clock);
    chk_eq("lda_done_clr", 16'(done), 16'd0);

    // 3: increment wrap, negative flag, clear
    bus_in = 16'hFFFF; issue(CMD_LDB, 4'd0);
    chk_eq("ffff_neg", 16'(neg), 16'd1);
    issue(CMD_INC, 4'd0);
    chk_eq("inc_wrap_ac", ac_out, 16'h0000);
    chk_eq("inc_wrap_zero", 16'(zero), 16'd1);
    bus_in = 16'h7FFF; issue(CMD_LDB, 4'd0);
    issue(CMD_INC, 4'd0);
    chk_eq("inc_7fff", ac_out, 16'h8000);
    bus_in = 16'h8000; issue(CMD_LDB, 4'd0);
    chk_eq("neg_8000", 16'(neg), 16'd1);
    issue(CMD_CLR, 4'd0);
    chk_eq("clr_ac", ac_out, 16'h0000);

    // 4: SHL by 4, then SHR by 15
    bus_in = 16'h0003; issue(CMD_LDB, 4'd0);
    issue(CMD_SHL, 4'd4);
    chk_eq("shl_acc_ac", ac_out, 16'h0003);
    chk_eq("shl_acc_busy", 16'(busy), 16'd1);
    chk_eq("shl_acc_ready", 16'(cmd_ready), 16'd0);
    chk_eq("shl_acc_done", 16'(done), 16'd0);
    begin
      logic [15:0] exp_seq [4];
      exp_seq[0] = 16'h0006; exp_seq[1] = 16'h000C; exp_seq[2] = 16'h0018; exp_seq[3] = 16'h0030;
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        chk_eq($sformatf("shl_step%0d_ac", i), ac_out, exp_seq[i]);
        chk_eq($sformatf("shl_step%0d_busy", i), 16'(busy), (i == 3) ? 16'd0 : 16'd1);
        chk_eq($sformatf("shl_step%0d_done", i), 16'(done), (i == 3) ? 16'd1 : 16'd0);
      end
    end
    @(negedge clock);
    chk_eq("shl_done_once", 16'(done), 16'd0);
    bus_in = 16'h8000; issue(CMD_LDB, 4'd0);
    issue(CMD_SHR, 4'd15);
    repeat (14) @(negedge clock);
    chk_eq("shr15_last_busy", 16'(busy), 16'd1);
    chk_eq("shr15_mid_ac", ac_out, 16'h0002);
    @(negedge clock);
    chk_eq("shr15_ac", ac_out, 16'h0001);
    chk_eq("shr15_done", 16'(done), 16'd1);
    chk_eq("shr15_ready", 16'(cmd_ready), 16'd1);

    // 5: zero-length shift, ignored command during SHIFT, reserved opcode
    bus_in = 16'h00A5; issue(CMD_LDB, 4'd0);
    issue(CMD_SHR, 4'd0);
    chk_eq("shr0_ac", ac_out, 16'h00A5);
    chk_eq("shr0_done", 16'(done), 16'd1);
    chk_eq("shr0_busy", 16'(busy), 16'd0);
    bus_in = 16'h0003; issue(CMD_LDB, 4'd0);
    issue(CMD_SHL, 4'd2);
    cmd = CMD_LDB; cmd_valid = 1'b1; bus_in = 16'hBEEF;
    @(negedge clock);
    chk_eq("ign_step0_ac", ac_out, 16'h0006);
    chk_eq("ign_step0_busy", 16'(busy), 16'd1);
    @(negedge clock);
    cmd_valid = 1'b0; cmd = CMD_NOP;
    chk_eq("ign_step1_ac", ac_out, 16'h000C);
    chk_eq("ign_step1_done", 16'(done), 16'd1);
    issue(3'd7, 4'd0);
    chk_eq("op7_ac", ac_out, 16'h000C);
    chk_eq("op7_done", 16'(done), 16'd1);

    // 6: reset during the 2nd cycle of SHL 8
    bus_in = 16'h0001; issue(CMD_LDB, 4'd0);
    issue(CMD_SHL, 4'd8);
    @(negedge clock);
    chk_eq("shl8_step0_ac", ac_out, 16'h0002);
    chk_eq("shl8_step0_busy", 16'(busy), 16'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_idle_reset("rst_shift");
    begin
      int stray = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      chk_eq("no_stray_done", 16'(stray), 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
